// File: rtl/kyber_pkg.sv
// Baby Kyber (q=17, n=4, k=2) shared types, constants and helpers.
// Used by the decrypt datapath and its MAC.
package kyber_pkg;
  localparam int Q     = 17;
  localparam int N     = 4;
  localparam int K     = 2;
  localparam int W     = 32;
  localparam int QHALF = 9;
  localparam int LO    = 5;
  localparam int HI    = 12;

  typedef logic signed [W-1:0] coeff_t;
  typedef logic [4:0]          red_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_FINAL,
    S_OUT
  } state_t;

  // true signed modulo: result always lands in [0,Q-1]
  function automatic red_t mod_q(input coeff_t a);
    coeff_t r;
    r = a % coeff_t'(Q);
    if (r < 0) r = r + coeff_t'(Q);
    return red_t'(r);
  endfunction

  function automatic logic decode(input red_t w);
    return (w >= red_t'(LO)) && (w <= red_t'(HI));
  endfunction
endpackage

// File: rtl/negacyclic_mac.sv
// One negacyclic multiply-accumulate step: mod_q(acc_in +/- a*b).
// sign=1 subtracts, covering terms that wrapped through x^4 = -1.
module negacyclic_mac
  import kyber_pkg::*;
(
  input  red_t a,
  input  red_t b,
  input  red_t acc_in,
  input  logic sign,
  output red_t acc_out
);
  logic [9:0]        prod;
  logic signed [9:0] sum;

  assign prod = {5'b0, a} * {5'b0, b};

  always_comb begin
    sum = $signed({5'b0, acc_in});
    if (sign) sum = sum - $signed(prod);
    else      sum = sum + $signed(prod);
  end

  assign acc_out = mod_q(coeff_t'(sum));
endmodule

// File: rtl/decrypt_seq.sv
// Baby Kyber decryption: w = v - s^T u mod q, then 1-bit decode per coeff.
// One MAC is time-multiplexed over all K*N*N products.
module decrypt_seq
  import kyber_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  coeff_t       u [K][N],
  input  coeff_t       v [N],
  input  coeff_t       s [K][N],
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] message,
  output logic         busy
);
  state_t     state, nstate;
  logic [4:0] p;
  red_t       ur [K][N];
  red_t       sr [K][N];
  red_t       vr [N];
  red_t       acc [N];

  logic       kk;
  logic [1:0] ii, jj, idx;
  logic [2:0] sum3;
  logic       wrap, last;
  red_t       mac_out;

  // p = {k, i, j}: k outer, i middle, j inner
  assign kk   = p[4];
  assign ii   = p[3:2];
  assign jj   = p[1:0];
  assign sum3 = {1'b0, ii} + {1'b0, jj};
  assign idx  = sum3[1:0];
  assign wrap = sum3[2];
  assign last = (p == 5'(K*N*N-1));

  negacyclic_mac u_mac (
    .a       (sr[kk][ii]),
    .b       (ur[kk][jj]),
    .acc_in  (acc[idx]),
    .sign    (wrap),
    .acc_out (mac_out)
  );

  assign in_ready  = rst_n && (state == S_IDLE);
  assign out_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:  if (in_valid) nstate = S_MAC;
      S_MAC:   if (last) nstate = S_FINAL;
      S_FINAL: nstate = S_OUT;
      S_OUT:   if (out_ready) nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p       <= '0;
      message <= '0;
      for (int k = 0; k < K; k++)
        for (int i = 0; i < N; i++) begin
          ur[k][i] <= '0;
          sr[k][i] <= '0;
        end
      for (int c = 0; c < N; c++) begin
        vr[c]  <= '0;
        acc[c] <= '0;
      end
    end else begin
      if (state == S_IDLE && in_valid) begin
        p <= '0;
        for (int k = 0; k < K; k++)
          for (int i = 0; i < N; i++) begin
            ur[k][i] <= mod_q(u[k][i]);
            sr[k][i] <= mod_q(s[k][i]);
          end
        for (int c = 0; c < N; c++) begin
          vr[c]  <= mod_q(v[c]);
          acc[c] <= '0;
        end
      end
      if (state == S_MAC) begin
        acc[idx] <= mac_out;
        p        <= p + 5'd1;
      end
      // coefficient 0 lands in the MSB
      if (state == S_FINAL)
        for (int c = 0; c < N; c++)
          message[N-1-c] <= decode(
            mod_q(coeff_t'(vr[c]) - coeff_t'(acc[c])));
    end
  end
endmodule

// File: tb/tb_decrypt_seq.sv
// Self-checking bench for decrypt_seq: directed vectors plus
// random small-noise encryptions decoded against a polynomial model.
module tb_decrypt_seq;
  import kyber_pkg::*;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         in_valid = 0;
  logic         out_ready = 0;
  logic         in_ready, out_valid, busy;
  logic [3:0]   message;
  coeff_t       u [K][N];
  coeff_t       v [N];
  coeff_t       s [K][N];

  int total = 0;
  int bad = 0;

  // edges from the accepting edge to the first cycle with out_valid
  localparam int LAT = 33;

  always #5 clk = ~clk;

  decrypt_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .u         (u),
    .v         (v),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .message   (message),
    .busy      (busy)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    for (int k = 0; k < K; k++)
      for (int i = 0; i < N; i++) begin
        u[k][i] = 0;
        s[k][i] = 0;
      end
    for (int c = 0; c < N; c++) v[c] = 0;
  endtask

  task automatic set_vec1;
    clear_in();
    s[0][0] = 1;
    v[0] = 9;
    v[2] = 9;
  endtask

  task automatic accept_job;
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask

  task automatic wait_out(output int lat, output logic [3:0] msg);
    int n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    lat = out_valid ? n : -1;
    msg = message;
  endtask

  task automatic finish_job;
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  // ---------------- reference model ----------------
  function automatic int mq(input int x);
    return ((x % 17) + 17) % 17;
  endfunction

  // acc += a*b in Z[x]/(x^4+1)
  function automatic void pmac(inout int acc[4], input int a[4],
                               input int b[4]);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (i + j < 4) acc[i+j] += a[i] * b[j];
        else           acc[i+j-4] -= a[i] * b[j];
  endfunction

  function automatic logic [3:0] ref_msg(input int uu[2][4],
                                         input int vv[4],
                                         input int ss[2][4]);
    int a[2][4];
    int b[2][4];
    int acc[4];
    int w;
    logic [3:0] r;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        a[k][i] = mq(ss[k][i]);
        b[k][i] = mq(uu[k][i]);
      end
    for (int c = 0; c < 4; c++) acc[c] = 0;
    for (int k = 0; k < 2; k++) pmac(acc, a[k], b[k]);
    for (int c = 0; c < 4; c++) begin
      w = mq(mq(vv[c]) - acc[c]);
      r[3-c] = (w >= 5 && w <= 12);
    end
    return r;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 0;
    tick();
    tick();
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_in_ready got=%b want=0", in_ready);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_out_valid got=%b want=0", out_valid);
    end
    total++;
    if (message !== 4'b0) begin
      bad++;
      $display("FAIL rst_message got=%b want=0000", message);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy got=%b want=0", busy);
    end
    rst_n = 1;
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_release_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_basic;
    int lat;
    logic [3:0] m;
    set_vec1();
    accept_job();
    wait_out(lat, m);
    total++;
    if (lat !== LAT) begin
      bad++;
      $display("FAIL basic_latency got=%0d want=%0d", lat, LAT);
    end
    total++;
    if (m !== 4'b1010) begin
      bad++;
      $display("FAIL basic_msg got=%b want=1010", m);
    end
    finish_job();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_release got=%b%b want=01", out_valid, in_ready);
    end
  endtask

  task automatic test_wrap;
    int lat;
    logic [3:0] m;
    clear_in();
    s[0][1] = 1;
    u[0][3] = 1;
    v[0] = 8;
    accept_job();
    wait_out(lat, m);
    total++;
    if (m !== 4'b1000 || lat !== LAT) begin
      bad++;
      $display("FAIL wrap_msg got=%b/%0d want=1000/%0d", m, lat, LAT);
    end
    finish_job();
  endtask

  task automatic test_thresholds;
    int lat;
    logic [3:0] m;
    int vt [3][4];
    logic [3:0] exp_m [3];
    vt[0] = '{4, 5, 12, 13};    exp_m[0] = 4'b0110;
    vt[1] = '{-8, 0, 0, 0};     exp_m[1] = 4'b1000;
    vt[2] = '{17, -17, 22, -5}; exp_m[2] = 4'b0011;
    for (int t = 0; t < 3; t++) begin
      clear_in();
      for (int c = 0; c < 4; c++) v[c] = vt[t][c];
      accept_job();
      wait_out(lat, m);
      total++;
      if (m !== exp_m[t]) begin
        bad++;
        $display("FAIL thresh_%0d got=%b want=%b", t, m, exp_m[t]);
      end
      finish_job();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [3:0] m;
    set_vec1();
    accept_job();
    wait_out(lat, m);
    total++;
    if (m !== 4'b1010) begin
      bad++;
      $display("FAIL bp_msg got=%b want=1010", m);
    end
    for (int n = 0; n < 10; n++) begin
      for (int c = 0; c < 4; c++) v[c] = $urandom_range(0, 16);
      in_valid = 1;
      tick();
      total++;
      if (out_valid !== 1'b1 || message !== 4'b1010 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d got=%b/%b/%b want=1/1010/0",
                 n, out_valid, message, in_ready);
      end
    end
    in_valid = 0;
    finish_job();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got=%b%b%b want=010",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [3:0] m;
    clear_in();
    s[0][1] = 1;
    u[0][3] = 1;
    v[0] = 8;
    accept_job();
    for (int n = 0; n < 14; n++) tick();
    rst_n = 0;
    tick();
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state got=%b%b want=00", busy, out_valid);
    end
    rst_n = 1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_in_ready got=%b want=1", in_ready);
    end
    set_vec1();
    accept_job();
    wait_out(lat, m);
    total++;
    if (m !== 4'b1010 || lat !== LAT) begin
      bad++;
      $display("FAIL midrst_job got=%b/%0d want=1010/%0d", m, lat, LAT);
    end
    finish_job();
  endtask

  task automatic test_back_to_back;
    int A [2][2][4];
    int sk [2][4];
    int r [2][4];
    int t [2][4];
    int ui [2][4];
    int vi [4];
    int acc [4];
    logic [3:0] mo, want, m;
    int lat;
    for (int job = 0; job < 20; job++) begin
      mo = 4'($urandom_range(0, 15));
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 4; i++) begin
          sk[k][i] = int'($urandom_range(0, 2)) - 1;
          r[k][i]  = int'($urandom_range(0, 2)) - 1;
          t[k][i]  = 0;
          ui[k][i] = 0;
          for (int l = 0; l < 2; l++) A[k][l][i] = $urandom_range(0, 16);
        end
      // t = A s, u = A^T r, v = t^T r + e2 + round(q/2)*m
      for (int k = 0; k < 2; k++)
        for (int l = 0; l < 2; l++) begin
          pmac(t[k], A[k][l], sk[l]);
          pmac(ui[k], A[l][k], r[l]);
        end
      for (int c = 0; c < 4; c++) acc[c] = 0;
      for (int k = 0; k < 2; k++) pmac(acc, t[k], r[k]);
      for (int c = 0; c < 4; c++)
        vi[c] = acc[c] + int'($urandom_range(0, 2)) - 1 + 9 * int'(mo[3-c]);
      // shift by random multiples of q to exercise signed reduction
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 4; i++) begin
          ui[k][i] += 17 * (int'($urandom_range(0, 6)) - 3);
          sk[k][i] += 17 * (int'($urandom_range(0, 6)) - 3);
          u[k][i] = ui[k][i];
          s[k][i] = sk[k][i];
        end
      for (int c = 0; c < 4; c++) begin
        vi[c] += 17 * (int'($urandom_range(0, 6)) - 3);
        v[c] = vi[c];
      end
      want = ref_msg(ui, vi, sk);
      accept_job();
      wait_out(lat, m);
      total++;
      if (m !== want || lat !== LAT) begin
        bad++;
        $display("FAIL b2b_model_%0d got=%b/%0d want=%b/%0d",
                 job, m, lat, want, LAT);
      end
      total++;
      if (m !== mo) begin
        bad++;
        $display("FAIL b2b_plain_%0d got=%b want=%b", job, m, mo);
      end
      for (int d = 0; d < int'(job % 3); d++) tick();
      finish_job();
    end
  endtask

  initial begin
    clear_in();
    test_reset();
    test_basic();
    test_wrap();
    test_thresholds();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decrypt_seq.md
Name: decrypt_seq

Overview:
- Baby Kyber decryption, the receive-side counterpart of the encrypt datapath (q=17, n=4, k=2, ring Z_q[x]/(x^4+1)).
- Accepts a ciphertext (u[2][4], v[4]) and secret key s[2][4]. Computes w = v − sᵀu mod q using one time-multiplexed negacyclic MAC, then decodes each coefficient to one message bit.
- Sits between the ciphertext source and the message sink, with valid/ready handshakes on both sides.

Parameters:
- Q, 17, modulus.
- N, 4, polynomial degree (coefficients per poly).
- K, 2, module rank (polys per vector).
- W, 32, signed input coefficient width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  ciphertext/key valid
- in_ready  out  1  block can accept a new job
- u  in  signed W x [K][N]  ciphertext vector u
- v  in  signed W x [N]  ciphertext poly v
- s  in  signed W x [K][N]  secret key
- out_valid  out  1  message valid
- out_ready  in  1  sink accepts message
- message  out  N  decoded bits
- busy  out  1  job in progress (not IDLE)

Behaviour:
- Reset values: in_ready=0 during reset, 1 in the first cycle after; out_valid=0; message=0; busy=0; accumulators=0; FSM=IDLE.
- Capture:
  - In IDLE, in_ready=1. On in_valid&&in_ready, register u, v, s.
  - Each coefficient is reduced with true signed modulo into [0,Q−1], so negative inputs wrap: −8→9, 17→0, −17→0.
- FSM: IDLE → MAC → FINAL → OUT → IDLE.
- MAC:
  - 32 cycles. Counter p=0..K·N·N−1 decomposes to (poly k, i, j).
  - Each cycle: idx=(i+j) mod N. Add s[k][i]·u[k][j] to acc[idx] when i+j<N, subtract it otherwise (x^4 = −1).
  - Each accumulator is re-reduced to [0,Q−1] every cycle. Products ≤16·16, so 10-bit signed intermediates suffice.
  - Iteration order: k outer, i middle, j inner.
- FINAL (1 cycle):
  - w[c] = (v[c] − acc[c]) mod Q, in [0,16].
  - Decode: bit=1 iff 5 ≤ w[c] ≤ 12, i.e. closest to q/2 = 9. Otherwise 0.
  - Bit mapping: message[N−1−c] = decode(w[c]), so coefficient 0 drives the MSB (matches the encrypt-side scaling order).
  - message is registered.
- OUT:
  - out_valid=1; message is stable while out_valid && !out_ready.
  - On out_ready, out_valid drops next cycle and FSM → IDLE, with in_ready=1 that same next cycle.
- Latency: accept at cycle T, MAC cycles T+1..T+32, FINAL at T+33, out_valid high from T+34. Throughput is one job per ≥35 cycles.
- in_ready=0 in MAC/FINAL/OUT. in_valid outside IDLE is ignored and nothing is captured.
- Reset asserted mid-job: job is aborted, all state returns to reset values next edge, and no out_valid is produced for the aborted job.
- Accumulators are cleared on capture, so there is no leakage between jobs.

Decomposition:
- Package kyber_pkg: Q, N, K, QHALF=9, decode thresholds LO=5 and HI=12, coeff_t (signed W), red_t (5-bit unsigned), function mod_q (signed → [0,Q−1]), FSM state enum.
- Sub-module negacyclic_mac: combinational. Takes a, b, acc_in, sign; outputs mod_q(acc_in ± a·b). Instantiated once.

Test Plan:
- s0=[1,0,0,0], s1=0, u=0, v=[9,0,9,0] → message=4'b1010 at T+34.
- Negacyclic wrap: s0=[0,1,0,0], u0=[0,0,0,1], s1=u1=0, v=[8,0,0,0] → acc=[16,0,0,0], w0=9 → message=4'b1000.
- Thresholds: s=0, v=[4,5,12,13] → message=4'b0110. Negative input: v=[−8,0,0,0] → 4'b1000.
- Backpressure: out_ready=0 for 10 cycles → out_valid and message stable, in_ready=0, and a second in_valid is ignored. Then out_ready=1 → out_valid drops, in_ready=1 next cycle.
- Reset at T+15 during MAC → next cycle busy=0, out_valid=0, in_ready=1. A new job with the first vector then yields 4'b1010 with correct latency.
- Random back-to-back jobs against a reference model (encrypt of random message/noise with small coefficients) → decoded message equals the original bits.
